// File: rtl/shifter_pkg.sv
// Shared constants for the shifter datapath and the arbiter that fronts it.
package shifter_pkg;
    localparam int DW     = 8;
    localparam int SMT_W  = 3;
    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] SH_SLL = 2'b00;
    localparam logic [MODE_W-1:0] SH_SRL = 2'b01;
    localparam logic [MODE_W-1:0] SH_SRA = 2'b10;
    localparam logic [MODE_W-1:0] SH_ROR = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;
endpackage

// File: rtl/barrel_shifter_8bit.sv
// Combinational 8-bit shifter: logical left/right, arithmetic right, rotate right.
module barrel_shifter_8bit
    import shifter_pkg::*;
(
    input  logic [DW-1:0]     data_i,
    input  logic [SMT_W-1:0]  smt_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [DW-1:0]     data_o
);
    logic [2*DW-1:0] rot;

    always_comb begin
        rot    = {data_i, data_i} >> smt_i;
        data_o = data_i;
        case (mode_i)
            SH_SLL:  data_o = data_i << smt_i;
            SH_SRL:  data_o = data_i >> smt_i;
            SH_SRA:  data_o = $signed(data_i) >>> smt_i;
            default: data_o = rot[DW-1:0];
        endcase
    end
endmodule

// File: rtl/shifter_rr_arbiter_rr_pick.sv
// Circular priority pick: first set request at or after ptr_i, wrapping at N.
module rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   gnt_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);
    int j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/shifter_rr_arbiter.sv
// Round-robin sharing of one barrel shifter between NREQ valid/ready requesters,
// with a one-entry tagged result register that supports back-to-back transfers.
module shifter_rr_arbiter
    import shifter_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DW-1:0]     req_data,
    input  logic [NREQ*SMT_W-1:0]  req_smt,
    input  logic [NREQ*MODE_W-1:0] req_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [IDW-1:0]         out_id
);
    state_e            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]     data_q;
    logic [IDW-1:0]    id_q;
    logic              can_accept, xfer;
    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    g;
    logic [DW-1:0]     sel_data, sh_out;
    logic [SMT_W-1:0]  sel_smt;
    logic [MODE_W-1:0] sel_mode;

    // Draining the held result frees the register in the same cycle.
    assign can_accept = (state_q == EMPTY) | out_ready;

    rr_pick #(.N(NREQ)) u_pick (
        .req_i (req_valid & {NREQ{can_accept}}),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (g),
        .any_o (xfer)
    );

    assign req_ready = gnt;

    always_comb begin
        sel_data = '0;
        sel_smt  = '0;
        sel_mode = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(g) == i) begin
                sel_data = req_data[i*DW +: DW];
                sel_smt  = req_smt[i*SMT_W +: SMT_W];
                sel_mode = req_mode[i*MODE_W +: MODE_W];
            end
        end
    end

    barrel_shifter_8bit u_shifter (
        .data_i (sel_data),
        .smt_i  (sel_smt),
        .mode_i (sel_mode),
        .data_o (sh_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (xfer) state_d = FULL;
            default: if (xfer) state_d = FULL;
                      else if (out_ready) state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) rr_ptr_d = (int'(g) == NREQ-1) ? '0 : g + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            data_q   <= '0;
            id_q     <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (xfer) begin
                data_q <= sh_out;
                id_q   <= g;
            end
        end
    end

    assign out_data = data_q;
    assign out_id   = id_q;
endmodule

// File: tb/tb_shifter_rr_arbiter.sv
// Directed bench with a reference round-robin/shifter model and a result scoreboard.
module tb_shifter_rr_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_data;
    logic [N*3-1:0] req_smt;
    logic [N*2-1:0] req_mode;
    logic           out_valid;
    logic           out_ready;
    logic [7:0]     out_data;
    logic [1:0]     out_id;

    shifter_rr_arbiter #(.NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_smt   (req_smt),
        .req_mode  (req_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   mptr  = 0;
    logic mfull = 1'b0;
    int   last_gnt = -1;
    int   order[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-by-bit reference shifter.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int s, input logic [1:0] m);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            case (m)
                2'b00:   r[i] = (i >= s) ? d[i-s] : 1'b0;
                2'b01:   r[i] = (i + s < 8) ? d[i+s] : 1'b0;
                2'b10:   r[i] = (i + s < 8) ? d[i+s] : d[7];
                default: r[i] = d[(i+s)%8];
            endcase
        end
        return r;
    endfunction

    task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
        req_data[i*8 +: 8] = d;
        req_smt[i*3 +: 3]  = s;
        req_mode[i*2 +: 2] = m;
    endtask

    // One clock: check grant and output against the model at negedge, then advance.
    task automatic cycle();
        int         g;
        logic [N-1:0] exp_rdy;
        exp_t       e;
        @(negedge clk);
        g = -1;
        exp_rdy = '0;
        if (!mfull || out_ready) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(mptr+k)%N]) g = (mptr + k) % N;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(mfull));
        if (mfull) begin
            if (sb.size() == 0) begin
                check("sb_nonempty", 32'(0), 32'(1));
            end else begin
                check("out_data", 32'(out_data), 32'(sb[0].d));
                check("out_id", 32'(out_id), 32'(sb[0].id));
            end
        end
        if (mfull && out_ready && sb.size() > 0) void'(sb.pop_front());
        last_gnt = g;
        if (g >= 0) begin
            e.id = g;
            e.d  = ref_shift(req_data[g*8 +: 8], int'(req_smt[g*3 +: 3]), req_mode[g*2 +: 2]);
            sb.push_back(e);
            mptr = (g + 1) % N;
        end
        mfull = (g >= 0) | (mfull & ~out_ready);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_smt = '0;
        req_mode = '0;
        out_ready = 1'b1;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_id", 32'(out_id), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single SLL request from req 0.
        set_req(0, 8'b10101010, 3'd3, 2'b00);
        req_valid = 4'b0001;
        cycle();
        check("t1_gnt", 32'(last_gnt), 32'(0));
        req_valid = '0;
        check("t1_valid", 32'(out_valid), 32'(1));
        check("t1_data", 32'(out_data), 32'(8'b01010000));
        check("t1_id", 32'(out_id), 32'(0));

        set_req(1, 8'b10101010, 3'd2, 2'b01);
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        check("srl_data", 32'(out_data), 32'(8'b00101010));

        set_req(2, 8'b11110000, 3'd1, 2'b10);
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        check("sra_data", 32'(out_data), 32'(8'b11111000));

        set_req(3, 8'b11010101, 3'd3, 2'b11);
        req_valid = 4'b1000;
        cycle();
        req_valid = '0;
        check("ror_data", 32'(out_data), 32'(8'b10111010));
        check("ror_id", 32'(out_id), 32'(3));

        // All requesters continuously valid: expect 0,1,2,3,0.
        for (int i = 0; i < N; i++) set_req(i, 8'(8'h11 * (i + 1)), 3'(i + 1), 2'(i));
        req_valid = 4'b1111;
        order.delete();
        repeat (5) begin
            cycle();
            order.push_back(last_gnt);
        end
        req_valid = '0;
        check("rr_g0", 32'(order[0]), 32'(0));
        check("rr_g1", 32'(order[1]), 32'(1));
        check("rr_g2", 32'(order[2]), 32'(2));
        check("rr_g3", 32'(order[3]), 32'(3));
        check("rr_g4", 32'(order[4]), 32'(0));

        // smt=0 passes through unchanged.
        set_req(1, 8'h9C, 3'd0, 2'b10);
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        check("smt0_data", 32'(out_data), 32'(8'h9C));

        // Backpressure: hold while FULL, req 0 waiting must not be granted.
        out_ready = 1'b0;
        set_req(0, 8'h0F, 3'd4, 2'b00);
        req_valid = 4'b0001;
        repeat (3) cycle();
        check("bp_data", 32'(out_data), 32'(8'h9C));
        check("bp_id", 32'(out_id), 32'(1));
        set_req(2, 8'h81, 3'd1, 2'b11);
        out_ready = 1'b1;
        req_valid = 4'b0101;
        cycle();
        check("bp_gnt", 32'(last_gnt), 32'(2));
        check("bp_new_data", 32'(out_data), 32'(8'hC0));
        req_valid = 4'b0001;
        cycle();
        check("bp_gnt2", 32'(last_gnt), 32'(0));
        req_valid = '0;
        cycle();

        // Fairness after idle.
        set_req(3, 8'h01, 3'd1, 2'b00);
        req_valid = 4'b1000;
        cycle();
        check("fair_g3", 32'(last_gnt), 32'(3));
        req_valid = 4'b1001;
        cycle();
        check("fair_g0", 32'(last_gnt), 32'(0));
        req_valid = 4'b1000;
        cycle();
        check("fair_g3b", 32'(last_gnt), 32'(3));
        req_valid = '0;
        cycle();

        // Async reset while FULL and stalled.
        set_req(1, 8'h42, 3'd1, 2'b00);
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        out_ready = 1'b0;
        cycle();
        #1 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'(0));
        check("arst_data", 32'(out_data), 32'(0));
        check("arst_id", 32'(out_id), 32'(0));
        #1 rst = 1'b0;
        mfull = 1'b0;
        mptr = 0;
        sb.delete();
        out_ready = 1'b1;
        set_req(3, 8'hFF, 3'd2, 2'b01);
        req_valid = 4'b1010;
        cycle();
        check("arst_gnt", 32'(last_gnt), 32'(1));
        req_valid = '0;
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shifter_rr_arbiter.md
Name: shifter_rr_arbiter

Overview:
Shares one barrel_shifter_8bit datapath between NREQ independent requesters. Each requester uses a valid/ready handshake. A round-robin arbiter picks one request per cycle and drives its operands into the shifter. The shift result is captured in a one-entry output register tagged with the requester ID. The output side uses valid/ready with backpressure and sustains one result per cycle.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ) (localparam), width of requester ID
DW, 8, data width; fixed at 8 to match barrel_shifter_8bit

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit set
req_data  in  NREQ*8  operand, requester i at [8i+7:8i]
req_smt  in  NREQ*3  shift amount 0..7, requester i at [3i+2:3i]
req_mode  in  NREQ*2  shift mode, requester i at [2i+1:2i]
out_valid  out  1  result register holds a valid result
out_ready  in  1  downstream accepts result
out_data  out  8  shift result
out_id  out  IDW  index of requester that issued the result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_id=0, rr_ptr=0, FSM=EMPTY.
- Reset mid-operation: any held result is discarded and no transfer completes.
- Mode encoding (shared package): 00 SLL, 01 SRL, 10 SRA (sign fill), 11 ROR.
- smt=0 passes data through unchanged in every mode.
- FSM states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_accept = (state==EMPTY) | out_ready.
- Grant rule:
  - When can_accept, g = first i with req_valid[i], searching circularly from rr_ptr.
  - req_ready = onehot(g). If no req_valid is set, or can_accept=0, req_ready=0.
  - req_ready is combinational from req_valid, state, out_ready and rr_ptr.
  - Requesters must not make req_valid depend on req_ready.
- Transfer: req_valid[g] & req_ready[g]. On transfer:
  - out_data <= shifter(req_data[g], req_smt[g], req_mode[g]).
  - out_id <= g.
  - state <= FULL.
  - rr_ptr <= (g+1) mod NREQ.
- Latency: result appears on out_valid exactly 1 cycle after its transfer.
- Drain:
  - FULL with out_ready=1 and no transfer -> EMPTY.
  - FULL with out_ready=1 and a transfer in the same cycle -> stays FULL with the new result. This is back-to-back operation, 1 result/cycle.
- Stall: FULL with out_ready=0 -> out_data and out_id hold stable, all req_ready=0.
- rr_ptr changes only on a transfer; it is unchanged while stalled or idle.
- Fairness: a continuously asserted request is granted within NREQ transfers.
- Requester rules: once req_valid is raised, it must stay high with stable operands until its transfer. The arbiter does not check this.
- out_valid never drops without out_ready.

Decomposition:
- Package shifter_pkg holds:
  - mode constants SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11
  - DW=8, SMT_W=3, MODE_W=2
  - FSM state constants EMPTY/FULL
- Sub-modules:
  - One existing barrel_shifter_8bit instance, fed by a mux selected by g.
  - One natural sub-module, rr_pick: combinational circular priority pick of (req vec, ptr) -> onehot grant, index, any.
- Top level holds the FSM, rr_ptr and the output register.

Test Plan:
- Single request, no backpressure, NREQ=4: req 0 sends data=8'b10101010, smt=3, SLL. Expect req_ready[0]=1 that cycle, out_valid=1 next cycle, out_data=8'b01010000, out_id=0.
- Per-mode results from one requester each:
  - 8'b10101010 SRL 2 -> 8'b00101010
  - 8'b11110000 SRA 1 -> 8'b11111000
  - 8'b11010101 ROR 3 -> 8'b10111010
  - any data with smt=0 -> unchanged
- All four requesters valid continuously, out_ready=1: grant order 0,1,2,3,0. One result per cycle. Each out_id matches the grant order.
- Backpressure: hold out_ready=0 for 3 cycles while FULL. out_data and out_id stay stable, req_ready=0. Raise out_ready together with req 2 valid: same-cycle drain plus accept, and the new result appears next cycle.
- Fairness after idle: only req 3 valid, then reqs 0 and 3 valid with rr_ptr=0 after wrap. Req 0 is granted before req 3 re-wins.
- Async reset: assert rst mid-cycle while FULL with out_ready=0. out_valid drops to 0 immediately without waiting for a clock edge. rr_ptr=0. After reset, the first grant goes to the lowest valid index.
